// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline sequencer (stall/flush arbitration, EX multi-cycle timing,
// stall-cycle counter). Define PIPE_TIMEOUT_EN to build the MEM bus-timeout trap.
module pipe_ctrl #(
   parameter int          CNT_W    = 6,
   parameter int          TIMEOUT  = 64,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0020
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id,
   input  logic             ex_mc_start,
   input  logic [CNT_W-1:0] ex_mc_len,
   output logic             ex_mc_done,
   input  logic             mem_req,
   input  logic             mem_ack,
   input  logic             flush_req,
   input  logic [31:0]      flush_pc,
   output logic [5:0]       stall,
   output logic             flush,
   output logic [31:0]      new_pc,
   output logic             bus_timeout,
   output logic [31:0]      stall_cycles
);

   typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_EX_WAIT = 1'b1} state_e;

   localparam logic [5:0]  STALL_NONE = 6'b000000;
   localparam logic [5:0]  STALL_ID   = 6'b000111;
   localparam logic [5:0]  STALL_EX   = 6'b001111;
   localparam logic [5:0]  STALL_MEM  = 6'b011111;
   localparam logic [31:0] SC_MAX     = 32'hFFFF_FFFF;

   if (TIMEOUT < 2) begin : g_timeout_range
      $error("pipe_ctrl: TIMEOUT must be at least 2");
   end

   state_e           state_r;
   state_e           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [31:0]      stall_cycles_r;
   logic             mem_stall_s;
   logic             timeout_s;
   logic             flush_s;
   logic             ex_stall_s;
   logic             done_s;
   logic [5:0]       stall_s;
   logic [31:0]      new_pc_s;

   assign mem_stall_s = mem_req & ~mem_ack;
   assign flush_s     = flush_req | timeout_s;

`ifdef PIPE_TIMEOUT_EN
   logic [31:0] to_cnt_r;
   logic        to_pend_r;
   logic        mem_run_s;

   // A flush cycle is not a granted MEM stall, so it breaks the run.
   assign mem_run_s = mem_stall_s & ~flush_s;

   // Count consecutive MEM stall cycles and arm the trap for the following cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         to_cnt_r  <= 32'd0;
         to_pend_r <= 1'b0;
      end else begin
         to_pend_r <= mem_run_s && (to_cnt_r == 32'(TIMEOUT - 1));
         if (mem_run_s) begin
            to_cnt_r <= to_cnt_r + 32'd1;
         end else begin
            to_cnt_r <= 32'd0;
         end
      end
   end

   assign timeout_s = to_pend_r;
`else
   assign timeout_s = 1'b0;
`endif

   // FSM state and EX occupancy counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // EX multi-cycle sequencing; a MEM stall freezes the countdown and withholds done.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      ex_stall_s  = 1'b0;
      done_s      = 1'b0;
      if (flush_s) begin
         state_nxt_s = ST_IDLE;
         cnt_nxt_s   = {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (ex_mc_start) begin
                  if (ex_mc_len >= CNT_W'(2)) begin
                     ex_stall_s  = 1'b1;
                     cnt_nxt_s   = ex_mc_len - CNT_W'(2);
                     state_nxt_s = ST_EX_WAIT;
                  end else begin
                     done_s = 1'b1;
                  end
               end else begin
                  done_s = 1'b0;
               end
            end
            ST_EX_WAIT: begin
               if (mem_stall_s) begin
                  ex_stall_s = 1'b1;
               end else if (cnt_r != {CNT_W{1'b0}}) begin
                  ex_stall_s = 1'b1;
                  cnt_nxt_s  = cnt_r - CNT_W'(1);
               end else begin
                  done_s      = 1'b1;
                  state_nxt_s = ST_IDLE;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Stall/flush priority: flush, then MEM, EX, ID; everything quiet while in reset.
   always_comb begin
      stall_s  = STALL_NONE;
      new_pc_s = 32'd0;
      if (!rst) begin
         stall_s = STALL_NONE;
      end else if (flush_req) begin
         new_pc_s = flush_pc;
      end else if (timeout_s) begin
         new_pc_s = TRAP_VEC;
      end else if (mem_stall_s) begin
         stall_s = STALL_MEM;
      end else if (ex_stall_s) begin
         stall_s = STALL_EX;
      end else if (stallreq_id) begin
         stall_s = STALL_ID;
      end else begin
         stall_s = STALL_NONE;
      end
   end

   // Saturating count of cycles in which the PC is held.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_r <= 32'd0;
      end else if (stall_s[0] && (stall_cycles_r != SC_MAX)) begin
         stall_cycles_r <= stall_cycles_r + 32'd1;
      end else begin
         stall_cycles_r <= stall_cycles_r;
      end
   end

   assign stall        = stall_s;
   assign new_pc       = new_pc_s;
   assign flush        = rst & flush_s;
   assign ex_mc_done   = rst & done_s;
   assign bus_timeout  = timeout_s;
   assign stall_cycles = stall_cycles_r;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl; directed test-plan sequences followed by
// randomized traffic, checked against a cycle-level behavioural model of the sequencer.
module tb_pipe_ctrl;
   localparam int          CNT_W   = 6;
   localparam int          TIMEOUT = 8;
   localparam logic [31:0] TRAP    = 32'h0000_0020;

   logic             clk = 1'b0;
   logic             rst;
   logic             stallreq_id, ex_mc_start, ex_mc_done;
   logic [CNT_W-1:0] ex_mc_len;
   logic             mem_req, mem_ack, flush_req, flush, bus_timeout;
   logic [31:0]      flush_pc, new_pc, stall_cycles;
   logic [5:0]       stall;

   always #5 clk = ~clk;

   pipe_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TRAP_VEC(TRAP)) dut (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .ex_mc_start(ex_mc_start),
      .ex_mc_len(ex_mc_len), .ex_mc_done(ex_mc_done), .mem_req(mem_req), .mem_ack(mem_ack),
      .flush_req(flush_req), .flush_pc(flush_pc), .stall(stall), .flush(flush),
      .new_pc(new_pc), .bus_timeout(bus_timeout), .stall_cycles(stall_cycles)
   );

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] new_pc;
      logic        done;
      logic        bto;
      logic [31:0] sc;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   // reference model: EX work remaining (non-frozen cycles), MEM run length, stall count
   bit     m_busy;
   int     m_left;
   int     m_run;
   bit     m_to_next;
   longint m_sc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 1'b0; m_left = 0; m_run = 0; m_to_next = 1'b0; m_sc = 0;
   endtask

   task automatic zero_inputs();
      stallreq_id = 1'b0; ex_mc_start = 1'b0; ex_mc_len = '0; mem_req = 1'b0;
      mem_ack = 1'b0; flush_req = 1'b0; flush_pc = 32'd0;
   endtask

   // Drive one cycle of inputs and push what the sequencer must show in that cycle.
   task automatic step(input bit id, input bit st, input int len, input bit mreq,
                       input bit mack, input bit fr, input logic [31:0] fpc);
      exp_t e;
      bit   to_now, fl, ms, ex_st, done;
      @(posedge clk); #1;
      stallreq_id = id; ex_mc_start = st; ex_mc_len = CNT_W'(len);
      mem_req = mreq; mem_ack = mack; flush_req = fr; flush_pc = fpc;
      to_now = m_to_next;
      fl = fr | to_now;
      ms = mreq & ~mack;
      ex_st = 1'b0; done = 1'b0;
      if (fl) begin
         m_busy = 1'b0;
      end else if (m_busy) begin
         if (ms) begin
            ex_st = 1'b1;
         end else begin
            m_left--;
            if (m_left == 0) begin done = 1'b1; m_busy = 1'b0; end
            else ex_st = 1'b1;
         end
      end else if (st) begin
         if (len <= 1) done = 1'b1;
         else begin m_busy = 1'b1; m_left = len - 1; ex_st = 1'b1; end
      end
      if (fl)          e.stall = 6'b000000;
      else if (ms)     e.stall = 6'b011111;
      else if (ex_st)  e.stall = 6'b001111;
      else if (id)     e.stall = 6'b000111;
      else             e.stall = 6'b000000;
      e.flush  = fl;
      e.new_pc = fr ? fpc : (to_now ? TRAP : 32'd0);
      e.done   = done;
      e.bto    = to_now;
      e.sc     = 32'(m_sc);
      if (e.stall[0] && m_sc < 64'hFFFF_FFFF) m_sc++;
`ifdef PIPE_TIMEOUT_EN
      m_run     = (ms && !fl) ? m_run + 1 : 0;
      m_to_next = (m_run == TIMEOUT);
`else
      m_to_next = 1'b0;
`endif
      exp_q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 32'd0);
   endtask

   // Monitor: every cycle the DUT presents a full output set; compare against the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall",        {26'd0, stall},       {26'd0, e.stall});
            chk("flush",        {31'd0, flush},       {31'd0, e.flush});
            chk("new_pc",       new_pc,               e.new_pc);
            chk("ex_mc_done",   {31'd0, ex_mc_done},  {31'd0, e.done});
            chk("bus_timeout",  {31'd0, bus_timeout}, {31'd0, e.bto});
            chk("stall_cycles", stall_cycles,         e.sc);
         end
      end
   end

   task automatic chk_quiet(input string tag);
      chk({tag, "_stall"},  {26'd0, stall},      32'd0);
      chk({tag, "_flush"},  {31'd0, flush},      32'd0);
      chk({tag, "_new_pc"}, new_pc,              32'd0);
      chk({tag, "_done"},   {31'd0, ex_mc_done}, 32'd0);
      chk({tag, "_bto"},    {31'd0, bus_timeout},32'd0);
      chk({tag, "_sc"},     stall_cycles,        32'd0);
   endtask

   initial begin
      bit id, st, mreq, mack, fr;
      int len;
      rst = 1'b0;
      zero_inputs();
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_quiet("reset");
      end
      #1 rst = 1'b1;

      step(1, 0, 0, 0, 0, 0, 32'd0); step(1, 0, 0, 0, 0, 0, 32'd0); idle(2);
      step(0, 1, 5, 0, 0, 0, 32'd0); idle(5);
      step(0, 1, 1, 0, 0, 0, 32'd0); idle(1);
      step(0, 1, 0, 0, 0, 0, 32'd0); idle(1);
      step(0, 1, 5, 0, 0, 0, 32'd0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0, 0, 32'd0);
      idle(5);
      step(0, 1, 5, 0, 0, 0, 32'd0); step(1, 0, 0, 0, 0, 0, 32'd0);
      step(1, 0, 0, 0, 0, 1, 32'h0000_0180); idle(5);
      step(0, 1, 4, 0, 0, 0, 32'd0); step(0, 1, 2, 0, 0, 0, 32'd0); idle(4);
      step(0, 1, 2, 0, 0, 0, 32'd0); idle(2);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0, 0, 32'd0);
      step(0, 0, 0, 1, 1, 0, 32'd0); idle(2);
      for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 0, 0, 32'd0);
      step(0, 0, 0, 1, 0, 1, 32'h0000_0400); idle(2);

      // asynchronous reset in the middle of an EX wait
      step(0, 1, 9, 0, 0, 0, 32'd0); step(1, 0, 0, 0, 0, 0, 32'd0);
      @(negedge clk); #1;
      rst = 1'b0; #1;
      chk_quiet("midreset");
      zero_inputs();
      @(negedge clk); #1;
      rst = 1'b1;
      model_reset();
      idle(10);

      for (int c = 0; c < 2000; c++) begin
         id   = ($urandom_range(0, 3) == 0);
         fr   = ($urandom_range(0, 19) == 0);
         mreq = ($urandom_range(0, 9) < 3);
         mack = mreq && ($urandom_range(0, 1) == 1);
         st   = ($urandom_range(0, 5) == 0) && !(mreq && !mack) && !fr;
         len  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 63) : $urandom_range(0, 10);
         step(id, st, len, mreq, mack, fr, $urandom);
      end
      idle(2);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      @(negedge clk); #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage core.
- Merges stall requests from ID (load-use), EX (multi-cycle ops) and MEM (bus wait) with exception flush requests.
- Drives the shared stall[5:0] vector and flush/new_pc to the PC, if_id, id_ex, ex_mem and mem_wb registers.
- Times EX multi-cycle operations internally and keeps a stall-cycle performance counter.

Parameters:
- CNT_W, 6, width of the multi-cycle length and counter.
- TIMEOUT, 64, MEM-stall cycles before a bus timeout (used only when the optional feature is enabled).
- TRAP_VEC, 32'h0000_0020, redirect PC on bus timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock domain, reset asynchronous and active-low (rst=0 resets).
- stallreq_id  in  1  load-use hazard; level, sampled each cycle.
- ex_mc_start  in  1  one-cycle pulse: EX has begun a multi-cycle op.
- ex_mc_len  in  CNT_W  total EX occupancy in cycles; valid with ex_mc_start.
- ex_mc_done  out  1  EX result valid this cycle; EX may advance.
- mem_req  in  1  MEM stage has an outstanding bus access.
- mem_ack  in  1  bus completes the access this cycle.
- flush_req  in  1  exception/eret taken this cycle.
- flush_pc  in  32  handler or EPC target for flush_req.
- stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1=hold.
- flush  out  1  clear all pipeline registers this cycle.
- new_pc  out  32  PC load value when flush=1, else 0.
- bus_timeout  out  1  one-cycle timeout pulse.
- stall_cycles  out  32  count of cycles with stall[0]=1; saturates at 32'hFFFF_FFFF.

Behaviour:
- Reset (rst=0, async):
  - State IDLE, counter 0, stall_cycles 0, timeout counter 0.
  - All outputs 0: stall=6'b000000, flush=0, new_pc=0, ex_mc_done=0, bus_timeout=0.
  - Reset mid-operation abandons any EX wait or MEM wait immediately.
- stall, flush, new_pc and ex_mc_done are combinational from the registered state and the current-cycle inputs; state advances on posedge clk.
- Priority, highest first:
  - flush_req: flush=1, new_pc=flush_pc, stall=000000.
  - MEM stall (mem_req & ~mem_ack): stall=011111.
  - EX stall: stall=001111.
  - stallreq_id: stall=000111.
  - none: stall=000000.
- A stall request is granted the same cycle it is raised.
- FSM states IDLE and EX_WAIT:
  - In IDLE, ex_mc_start with len<=1: no stall, ex_mc_done=1 the same cycle, stay IDLE.
  - In IDLE, ex_mc_start with len=N>=2: EX stall this cycle, cnt<=N-2, go to EX_WAIT.
  - In EX_WAIT with cnt!=0: EX stall, cnt decrements.
  - In EX_WAIT with cnt==0: ex_mc_done=1, EX stall released, go to IDLE.
  - Result: N-1 stall cycles total; done arrives in cycle N counting the start cycle as 1.
- MEM stall during EX_WAIT: cnt is frozen and ex_mc_done is suppressed until MEM releases; stall shows 011111.
- flush_req in any state: the next state is IDLE, cnt is cleared and ex_mc_done=0. The flush lasts exactly one cycle for each cycle flush_req is high.
- ex_mc_start while already in EX_WAIT is a protocol error: ignored, count unchanged.
- stall_cycles increments each cycle in which stall[0]=1, and holds at the maximum value.

Optional Feature:
- Macro PIPE_TIMEOUT_EN.
- Defined:
  - The timeout counter increments on every cycle of continuous MEM stall and clears when the MEM stall ends or on flush.
  - On reaching TIMEOUT-1 cycles, bus_timeout=1 and flush=1 with new_pc=TRAP_VEC in the next cycle.
  - In that cycle stall=000000 and the FSM returns to IDLE.
  - If flush_req is high in the same cycle, flush_pc wins and bus_timeout still pulses.
- Not defined: the MEM stall holds indefinitely; bus_timeout is tied to 0 and no timeout counter is built.

Test Plan:
- Release rst after 3 cycles with all inputs 0 -> stall=000000, flush=0, new_pc=0, stall_cycles=0, held throughout reset.
- stallreq_id=1 for 2 cycles -> stall=000111 for those 2 cycles only; stall_cycles=2.
- ex_mc_start, ex_mc_len=5 -> stall=001111 for 4 cycles; ex_mc_done=1 in the 5th cycle with stall=000000; ex_mc_len=1 -> done in the same cycle with no stall.
- ex_mc_len=5, then mem_req=1, mem_ack=0 for 3 cycles starting in cycle 2 -> stall=011111 for 3 cycles; done delayed 3 cycles to cycle 8.
- flush_req=1, flush_pc=32'h0000_0180 during EX_WAIT with stallreq_id=1 -> flush=1, new_pc=32'h180, stall=000000; next cycle FSM in IDLE and no ex_mc_done.
- With PIPE_TIMEOUT_EN and TIMEOUT=8: mem_req=1, mem_ack=0 held -> stall=011111 for 8 cycles, then a one-cycle bus_timeout=1 and flush=1 with new_pc=32'h20. Without the macro, the stall persists and bus_timeout stays 0.
